// File: rtl/sdrc_wb_arb_pkg.sv
// Shared types and constants for the sdrc Wishbone arbiters.
//   arb_state_e : arbiter FSM state (idle / bus cycle in flight / watchdog abort)
//   CTI_*       : Wishbone cycle-type identifiers seen on m_cti_i / s_cti_o
package sdrc_wb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StAbort = 2'd2
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/sdrc_wb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   ptr_i   : index of the highest-priority requester this round
//   req_i   : request vector
//   gnt_o   : one-hot grant to the first requester at or after ptr_i (wrapping N-1 -> 0)
//   valid_o : at least one request present
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [PW-1:0] ptr_i,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o
);

  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr_i) + i) % N;
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdrc_wb_rr_arbiter.sv
// Round-robin Wishbone arbiter in front of the sdrc_top slave port.
//   wb_clk_i / wb_rst_i : clock, synchronous active-high reset
//   sdr_init_done       : no new grant is issued while low
//   m_*_i / m_*_o       : NUM_M packed master ports (master i at [i*W +: W])
//   s_*_o / s_*_i       : single slave port towards sdrc_top
//   gnt_o               : registered one-hot grant, zero when idle
// A grant is held for the full bus cycle (cyc high, bursts included). A watchdog
// counts stalled strobe cycles and aborts the cycle with a one-cycle err pulse.
module sdrc_wb_rr_arbiter
  import sdrc_wb_arb_pkg::*;
#(
  parameter int unsigned NUM_M   = 4,
  parameter int unsigned APP_AW  = 26,
  parameter int unsigned DW      = 32,
  parameter int unsigned SW      = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  sdr_init_done,
  input  logic [NUM_M-1:0]      m_cyc_i,
  input  logic [NUM_M-1:0]      m_stb_i,
  input  logic [NUM_M-1:0]      m_we_i,
  input  logic [NUM_M*APP_AW-1:0] m_addr_i,
  input  logic [NUM_M*DW-1:0]   m_dat_i,
  input  logic [NUM_M*SW-1:0]   m_sel_i,
  input  logic [NUM_M*3-1:0]    m_cti_i,
  output logic [DW-1:0]         m_dat_o,
  output logic [NUM_M-1:0]      m_ack_o,
  output logic [NUM_M-1:0]      m_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [APP_AW-1:0]     s_addr_o,
  output logic [DW-1:0]         s_dat_o,
  output logic [SW-1:0]         s_sel_o,
  output logic [2:0]            s_cti_o,
  input  logic [DW-1:0]         s_dat_i,
  input  logic                  s_ack_i,
  output logic [NUM_M-1:0]      gnt_o
);

  localparam int unsigned PW  = $clog2(NUM_M);
  localparam int unsigned WdW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_e       state_q, state_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [WdW-1:0]   wdog_q, wdog_d;
  logic             err_q, err_d;

  logic [NUM_M-1:0] pick_gnt;
  logic             pick_valid;
  logic [PW-1:0]    g_idx;
  logic [PW-1:0]    next_ptr;
  logic             g_cyc;
  logic             busy;
  logic             wdog_hit;

  rr_pick #(
    .N (NUM_M)
  ) u_rr_pick (
    .ptr_i   (ptr_q),
    .req_i   (m_cyc_i),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  // Binary index of the held grant; drives every slave-side mux.
  always_comb begin
    g_idx = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (gnt_q[i]) g_idx = PW'(i);
    end
  end

  assign next_ptr = (g_idx == PW'(NUM_M - 1)) ? '0 : g_idx + PW'(1);
  assign busy     = (state_q == StBusy);
  assign g_cyc    = m_cyc_i[g_idx];

  // Slave port: data-path fields always follow the grant, handshake only while BUSY.
  assign s_cyc_o  = busy & g_cyc;
  assign s_stb_o  = busy & m_stb_i[g_idx];
  assign s_we_o   = m_we_i[g_idx];
  assign s_addr_o = m_addr_i[g_idx*APP_AW +: APP_AW];
  assign s_dat_o  = m_dat_i[g_idx*DW +: DW];
  assign s_sel_o  = m_sel_i[g_idx*SW +: SW];
  assign s_cti_o  = m_cti_i[g_idx*3 +: 3];

  // An ack arriving outside BUSY (e.g. late, after an abort) is dropped here.
  assign m_ack_o = (busy && s_ack_i) ? gnt_q : '0;
  assign m_err_o = err_q ? gnt_q : '0;
  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt_q;

  assign wdog_hit = (TIMEOUT != 0) && (wdog_q == WdW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    wdog_d  = '0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (sdr_init_done && pick_valid) begin
          gnt_d   = pick_gnt;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!g_cyc) begin
          state_d = StIdle;
          gnt_d   = '0;
          ptr_d   = next_ptr;
        end else if (s_stb_o && !s_ack_i) begin
          // Ack on the same edge as the would-be timeout takes this branch's else path.
          if (wdog_hit) begin
            state_d = StAbort;
            err_d   = 1'b1;
          end else if (TIMEOUT != 0) begin
            wdog_d = wdog_q + WdW'(1);
          end
        end
      end
      StAbort: begin
        if (!g_cyc) begin
          state_d = StIdle;
          gnt_d   = '0;
          ptr_d   = next_ptr;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ptr_q   <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_sdrc_wb_rr_arbiter.sv
// Directed bench for sdrc_wb_rr_arbiter with a one-wait-state behavioural slave.
module tb_sdrc_wb_rr_arbiter;

  localparam int unsigned NUM_M   = 4;
  localparam int unsigned APP_AW  = 26;
  localparam int unsigned DW      = 32;
  localparam int unsigned SW      = 4;
  localparam int unsigned TIMEOUT = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    init;
  logic [NUM_M-1:0]        m_cyc, m_stb, m_we;
  logic [NUM_M*APP_AW-1:0] m_addr;
  logic [NUM_M*DW-1:0]     m_dat;
  logic [NUM_M*SW-1:0]     m_sel;
  logic [NUM_M*3-1:0]      m_cti;
  logic [DW-1:0]           m_dat_o;
  logic [NUM_M-1:0]        m_ack, m_err, gnt;
  logic                    s_cyc, s_stb, s_we;
  logic [APP_AW-1:0]       s_addr;
  logic [DW-1:0]           s_dat;
  logic [SW-1:0]           s_sel;
  logic [2:0]              s_cti;
  logic [DW-1:0]           rdata;
  logic                    ack_q;
  logic                    mute;
  logic [DW-1:0]           mem [0:255];

  int checks;
  int failures;

  sdrc_wb_rr_arbiter #(
    .NUM_M   (NUM_M),
    .APP_AW  (APP_AW),
    .DW      (DW),
    .SW      (SW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .sdr_init_done (init),
    .m_cyc_i       (m_cyc),
    .m_stb_i       (m_stb),
    .m_we_i        (m_we),
    .m_addr_i      (m_addr),
    .m_dat_i       (m_dat),
    .m_sel_i       (m_sel),
    .m_cti_i       (m_cti),
    .m_dat_o       (m_dat_o),
    .m_ack_o       (m_ack),
    .m_err_o       (m_err),
    .s_cyc_o       (s_cyc),
    .s_stb_o       (s_stb),
    .s_we_o        (s_we),
    .s_addr_o      (s_addr),
    .s_dat_o       (s_dat),
    .s_sel_o       (s_sel),
    .s_cti_o       (s_cti),
    .s_dat_i       (rdata),
    .s_ack_i       (ack_q),
    .gnt_o         (gnt)
  );

  always #5 clk = ~clk;

  // Slave: registered ack one cycle after a strobe, never two acks back to back.
  always @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
    end else if (s_cyc && s_stb && !ack_q && !mute) begin
      ack_q <= 1'b1;
      if (s_we) mem[s_addr[7:0]] <= s_dat;
      else      rdata <= mem[s_addr[7:0]];
    end else begin
      ack_q <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL tb_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [3:0] exp_g;
    logic       done;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    init     = 1'b0;
    mute     = 1'b0;
    m_cyc    = '1;
    m_stb    = '0;
    m_we     = '0;
    m_addr   = '0;
    m_dat    = '0;
    m_sel    = '1;
    m_cti    = '0;

    // Reset state
    tick();
    tick();
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_scyc", 64'(s_cyc), 64'h0);
    chk("rst_ack", 64'(m_ack), 64'h0);
    chk("rst_err", 64'(m_err), 64'h0);
    rst = 1'b0;

    // No grant while init is low
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("noinit_gnt", 64'(gnt), 64'h0);
      chk("noinit_scyc", 64'(s_cyc), 64'h0);
    end

    // All masters requesting: order 0,1,2,3,0 with an idle cycle between
    init  = 1'b1;
    m_cyc = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      tick();
      chk("rr_gnt", 64'(gnt), 64'(exp_g));
      chk("rr_scyc", 64'(s_cyc), 64'h1);
      m_cyc = 4'b1111 & ~exp_g;
      tick();
      chk("rr_idle", 64'(gnt), 64'h0);
      m_cyc = 4'b1111;
    end
    m_cyc = '0;
    tick();

    // Master 2 write then read back
    m_we[2]          = 1'b1;
    m_addr[52 +: 26] = 26'h0000040;
    m_dat[64 +: 32]  = 32'hDEADBEEF;
    m_cti[6 +: 3]    = 3'b000;
    m_cyc            = 4'b0100;
    m_stb            = 4'b0100;
    tick();
    chk("wr_gnt", 64'(gnt), 64'h4);
    chk("wr_addr", 64'(s_addr), 64'h40);
    chk("wr_dat", 64'(s_dat), 64'hDEADBEEF);
    chk("wr_we", 64'(s_we), 64'h1);
    tick();
    chk("wr_ack", 64'(m_ack), 64'h4);
    m_cyc   = '0;
    m_stb   = '0;
    m_we[2] = 1'b0;
    tick();
    chk("wr_release", 64'(gnt), 64'h0);
    m_cyc = 4'b0100;
    m_stb = 4'b0100;
    tick();
    chk("rd_gnt", 64'(gnt), 64'h4);
    tick();
    chk("rd_ack", 64'(m_ack), 64'h4);
    chk("rd_dat", 64'(m_dat_o), 64'hDEADBEEF);
    m_cyc = '0;
    m_stb = '0;
    tick();

    // Master 1 eight-beat INCR burst while master 3 also requests
    m_we[1]          = 1'b1;
    m_addr[26 +: 26] = 26'h100;
    m_cti[3 +: 3]    = 3'b010;
    m_cyc            = 4'b0010;
    m_stb            = 4'b0010;
    tick();
    chk("burst_gnt", 64'(gnt), 64'h2);
    m_cyc = 4'b1010;
    for (int beat = 0; beat < 8; beat++) begin
      m_cti[3 +: 3]    = (beat == 7) ? 3'b111 : 3'b010;
      m_dat[32 +: 32]  = 32'(beat);
      m_addr[26 +: 26] = 26'h100 + 26'(beat);
      done = 1'b0;
      for (int w = 0; w < 8 && !done; w++) begin
        tick();
        chk("burst_hold", 64'(gnt), 64'h2);
        if (m_ack[1]) done = 1'b1;
      end
      chk("burst_ack", 64'(m_ack), 64'h2);
    end
    chk("burst_cti", 64'(s_cti), 64'h7);
    m_cyc   = 4'b1000;
    m_stb   = '0;
    m_we[1] = 1'b0;
    tick();
    chk("burst_release", 64'(gnt), 64'h0);
    tick();
    chk("after_burst_gnt", 64'(gnt), 64'h8);
    m_cyc = '0;
    tick();

    // Watchdog: slave never acks master 0
    mute  = 1'b1;
    m_cyc = 4'b0011;
    m_stb = 4'b0011;
    tick();
    chk("wd_gnt", 64'(gnt), 64'h1);
    for (int n = 1; n < 16; n++) begin
      tick();
      chk("wd_noerr", 64'(m_err), 64'h0);
    end
    chk("wd_scyc_busy", 64'(s_cyc), 64'h1);
    tick();
    chk("wd_err", 64'(m_err), 64'h1);
    chk("wd_scyc", 64'(s_cyc), 64'h0);
    chk("wd_sstb", 64'(s_stb), 64'h0);
    tick();
    chk("wd_err_pulse", 64'(m_err), 64'h0);
    chk("wd_hold_gnt", 64'(gnt), 64'h1);
    m_cyc = 4'b0010;
    m_stb = 4'b0010;
    mute  = 1'b0;
    tick();
    chk("wd_release", 64'(gnt), 64'h0);
    tick();
    chk("wd_next_gnt", 64'(gnt), 64'h2);
    tick();
    chk("wd_next_ack", 64'(m_ack), 64'h2);
    m_cyc = '0;
    m_stb = '0;
    tick();

    // Reset in the middle of a burst
    m_cti[6 +: 3] = 3'b010;
    m_cyc         = 4'b0110;
    m_stb         = 4'b0100;
    tick();
    chk("mrst_gnt", 64'(gnt), 64'h4);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_gnt0", 64'(gnt), 64'h0);
    chk("mrst_scyc", 64'(s_cyc), 64'h0);
    rst   = 1'b0;
    m_cyc = 4'b1111;
    m_stb = '0;
    tick();
    chk("post_rst_gnt", 64'(gnt), 64'h1);
    m_cyc = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
